// File: rtl/stream_pack_sched_pkg.sv
// rtl/stream_pack_sched_pkg.sv - shared constants and state type for the packer scheduler
package stream_pack_sched_pkg;

  localparam int ACT_DATA_WIDTH = 8;
  localparam int N_DIM_ARRAY    = 4;
  localparam int BEAT_WIDTH     = ACT_DATA_WIDTH * N_DIM_ARRAY;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    SECOND = 2'd1,
    PAD    = 2'd2
  } sched_state_e;

endpackage

// File: rtl/stream_pack_rr_arb.sv
// rtl/stream_pack_rr_arb.sv - 2-way round-robin selector, combinational
module stream_pack_rr_arb (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic       sel,
  output logic       any_valid
);

  // Prefer the requester at rr_ptr; fall back to the other one when it is idle.
  always_comb begin
    any_valid = |valid;
    sel       = rr_ptr;
    if (!valid[rr_ptr] && valid[~rr_ptr]) begin
      sel = ~rr_ptr;
    end
  end

endmodule

// File: rtl/stream_pack_sched.sv
// rtl/stream_pack_sched.sv - pair-atomic scheduler in front of the 32b-to-64b packer; optional STREAM_PACK_SCHED_STATS_EN adds statistics counters
module stream_pack_sched #(
  parameter int ACT_DATA_WIDTH = stream_pack_sched_pkg::ACT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req0_valid,
  input  logic [4*ACT_DATA_WIDTH-1:0] req0_word,
  input  logic                        req0_last,
  output logic                        req0_ready,
  input  logic                        req1_valid,
  input  logic [4*ACT_DATA_WIDTH-1:0] req1_word,
  input  logic                        req1_last,
  output logic                        req1_ready,
  input  logic [ADDR_WIDTH-1:0]       cfg_base0,
  input  logic [ADDR_WIDTH-1:0]       cfg_base1,
  input  logic                        cfg_load,
  input  logic                        out_ready,
  output logic                        pk_input_en,
  output logic [4*ACT_DATA_WIDTH-1:0] pk_input_word,
  output logic [ADDR_WIDTH-1:0]       pk_input_addr,
  output logic                        pk_owner,
`ifdef STREAM_PACK_SCHED_STATS_EN
  output logic [CNT_WIDTH-1:0]        stat_pairs0,
  output logic [CNT_WIDTH-1:0]        stat_pairs1,
  output logic [CNT_WIDTH-1:0]        stat_pads,
`endif
  output logic                        busy
);

  import stream_pack_sched_pkg::*;

  localparam int W = 4 * ACT_DATA_WIDTH;

  sched_state_e state, state_nxt;
  logic owner, owner_nxt;
  logic rr_ptr, rr_nxt;
  logic [ADDR_WIDTH-1:0] addr0, addr1;

  logic sel, any_valid;
  logic hs0, hs1, hs;
  logic beat_src, beat_last;
  logic [W-1:0] beat_word;
  logic pad_emit, pair_done, load_now, emit, emit_owner;

  stream_pack_rr_arb u_arb (
    .valid     ({req1_valid, req0_valid}),
    .rr_ptr    (rr_ptr),
    .sel       (sel),
    .any_valid (any_valid)
  );

  // Ready is granted only to the arbitration winner in ARB and only to the owner in SECOND.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      ARB: begin
        if (out_ready && any_valid && !cfg_load) begin
          req0_ready = !sel;
          req1_ready = sel;
        end
      end
      SECOND: begin
        if (out_ready) begin
          req0_ready = !owner;
          req1_ready = owner;
        end
      end
      default: begin
      end
    endcase
  end

  // Handshake decode and the beat/owner that will be presented to the packer.
  always_comb begin
    hs0        = req0_valid && req0_ready;
    hs1        = req1_valid && req1_ready;
    hs         = hs0 || hs1;
    beat_src   = hs1;
    beat_word  = hs1 ? req1_word : req0_word;
    beat_last  = hs1 ? req1_last : req0_last;
    pad_emit   = (state == PAD) && out_ready;
    pair_done  = ((state == SECOND) && hs) || pad_emit;
    load_now   = (state == ARB) && cfg_load;
    emit       = hs || pad_emit;
    emit_owner = (state == ARB) ? beat_src : owner;
  end

  // Next-state logic: a pair is always closed by a second beat or a pad before re-arbitrating.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    case (state)
      ARB: begin
        if (hs) begin
          owner_nxt = beat_src;
          state_nxt = beat_last ? PAD : SECOND;
        end
      end
      SECOND: begin
        if (hs) begin
          rr_nxt    = ~owner;
          state_nxt = ARB;
        end
      end
      PAD: begin
        if (out_ready) begin
          rr_nxt    = ~owner;
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ARB;
      owner  <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Per-requester 64b destination counters: loaded in ARB, bumped once per completed pair.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr0 <= '0;
      addr1 <= '0;
    end else if (load_now) begin
      addr0 <= cfg_base0;
      addr1 <= cfg_base1;
    end else if (pair_done) begin
      if (owner) begin
        addr1 <= addr1 + ADDR_WIDTH'(1);
      end else begin
        addr0 <= addr0 + ADDR_WIDTH'(1);
      end
    end
  end

  // Output register stage: one beat per cycle, address is the pre-increment pair address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pk_input_en   <= 1'b0;
      pk_input_word <= '0;
      pk_input_addr <= '0;
      pk_owner      <= 1'b0;
    end else begin
      pk_input_en <= emit;
      if (emit) begin
        pk_input_word <= pad_emit ? '0 : beat_word;
        pk_input_addr <= emit_owner ? addr1 : addr0;
        pk_owner      <= emit_owner;
      end
    end
  end

  assign busy = (state != ARB);

`ifdef STREAM_PACK_SCHED_STATS_EN
  // Saturating pair and pad counters, cleared together with an honoured address load.
  always_ff @(posedge clk) begin
    if (!reset || load_now) begin
      stat_pairs0 <= '0;
      stat_pairs1 <= '0;
      stat_pads   <= '0;
    end else begin
      if (pair_done && !owner && (stat_pairs0 != {CNT_WIDTH{1'b1}})) begin
        stat_pairs0 <= stat_pairs0 + CNT_WIDTH'(1);
      end
      if (pair_done && owner && (stat_pairs1 != {CNT_WIDTH{1'b1}})) begin
        stat_pairs1 <= stat_pairs1 + CNT_WIDTH'(1);
      end
      if (pad_emit && (stat_pads != {CNT_WIDTH{1'b1}})) begin
        stat_pads <= stat_pads + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_pack_sched.sv
// tb/tb_stream_pack_sched.sv - randomized and directed bench with a reference model for stream_pack_sched
module tb_stream_pack_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0_valid, req0_last, req1_valid, req1_last;
  logic [31:0] req0_word, req1_word, cfg_base0, cfg_base1;
  logic        cfg_load, out_ready;
  logic        req0_ready, req1_ready;
  logic        pk_input_en, pk_owner, busy;
  logic [31:0] pk_input_word, pk_input_addr;
`ifdef STREAM_PACK_SCHED_STATS_EN
  logic [15:0] stat_pairs0, stat_pairs1, stat_pads;
`endif

  stream_pack_sched dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_word     (req0_word),
    .req0_last     (req0_last),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_word     (req1_word),
    .req1_last     (req1_last),
    .req1_ready    (req1_ready),
    .cfg_base0     (cfg_base0),
    .cfg_base1     (cfg_base1),
    .cfg_load      (cfg_load),
    .out_ready     (out_ready),
    .pk_input_en   (pk_input_en),
    .pk_input_word (pk_input_word),
    .pk_input_addr (pk_input_addr),
    .pk_owner      (pk_owner),
`ifdef STREAM_PACK_SCHED_STATS_EN
    .stat_pairs0   (stat_pairs0),
    .stat_pairs1   (stat_pairs1),
    .stat_pads     (stat_pads),
`endif
    .busy          (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = arbitrating, 1 = waiting for the partner beat, 2 = pad owed.
  int          m_phase = 0;
  bit          m_owner = 0, m_rr = 0;
  logic [31:0] m_addr [2];
  bit          e_en = 0, e_owner = 0;
  logic [31:0] e_word = 0, e_addr = 0;
  bit          started = 0;

  logic [31:0] lq_word[$];
  logic [31:0] lq_addr[$];
  bit          lq_own[$];

  function automatic bit [1:0] model_ready();
    bit [1:0] r = 2'b00;
    if (m_phase == 0) begin
      if (out_ready && !cfg_load) begin
        if (req0_valid && req1_valid) r[m_rr] = 1'b1;
        else if (req0_valid)          r[0] = 1'b1;
        else if (req1_valid)          r[1] = 1'b1;
      end
    end else if (m_phase == 1) begin
      if (out_ready) r[m_owner] = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk) begin : model
    bit [1:0] hsv;
    bit       n;
    hsv = model_ready() & {req1_valid, req0_valid};
    n   = hsv[1];
    if (!reset) begin
      started = 1;
      m_phase = 0; m_owner = 0; m_rr = 0;
      m_addr[0] = 0; m_addr[1] = 0;
      e_en = 0; e_word = 0; e_addr = 0; e_owner = 0;
    end else begin
      e_en = 0;
      case (m_phase)
        0: begin
          if (cfg_load) begin
            m_addr[0] = cfg_base0;
            m_addr[1] = cfg_base1;
          end else if (hsv != 0) begin
            e_en = 1; e_owner = n; e_addr = m_addr[n];
            e_word = n ? req1_word : req0_word;
            m_owner = n;
            m_phase = (n ? req1_last : req0_last) ? 2 : 1;
          end
        end
        1: begin
          if (hsv != 0) begin
            e_en = 1; e_owner = m_owner; e_addr = m_addr[m_owner];
            e_word = m_owner ? req1_word : req0_word;
            m_addr[m_owner] = m_addr[m_owner] + 1;
            m_rr = !m_owner;
            m_phase = 0;
          end
        end
        default: begin
          if (out_ready) begin
            e_en = 1; e_owner = m_owner; e_addr = m_addr[m_owner]; e_word = 0;
            m_addr[m_owner] = m_addr[m_owner] + 1;
            m_rr = !m_owner;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    if (started) begin
      chk("ready", {req1_ready, req0_ready}, model_ready());
      chk("busy", busy, (m_phase != 0));
      chk("en", pk_input_en, e_en);
      if (e_en) begin
        chk("word", pk_input_word, e_word);
        chk("addr", pk_input_addr, e_addr);
        chk("owner", pk_owner, e_owner);
      end
      if (pk_input_en === 1'b1) begin
        lq_word.push_back(pk_input_word);
        lq_addr.push_back(pk_input_addr);
        lq_own.push_back(pk_owner);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_last = 0; req1_last = 0;
    req0_word = 0; req1_word = 0; cfg_load = 0; out_ready = 1;
  endtask

  task automatic do_reset_load(input logic [31:0] b0, input logic [31:0] b1);
    idle_inputs();
    reset = 0;
    step();
    reset = 1;
    cfg_base0 = b0; cfg_base1 = b1; cfg_load = 1;
    step();
    cfg_load = 0;
    lq_word.delete(); lq_addr.delete(); lq_own.delete();
  endtask

  task automatic chk_log(input string name, input int i, input bit own, input logic [31:0] addr,
                         input logic [31:0] word, input bit check_word);
    if (i < lq_addr.size()) begin
      chk({name, "_own"}, lq_own[i], own);
      chk({name, "_addr"}, lq_addr[i], addr);
      if (check_word) chk({name, "_word"}, lq_word[i], word);
    end else begin
      chk({name, "_missing"}, i, lq_addr.size());
    end
  endtask

  int          exp_own  [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
  logic [31:0] exp_addr [8] = '{32'h10, 32'h10, 32'h20, 32'h20, 32'h11, 32'h11, 32'h21, 32'h21};
  logic [31:0] t3_word  [6] = '{32'hA, 32'hB, 32'hC, 32'h0, 32'hD, 32'h0};
  logic [31:0] t3_addr  [6] = '{32'h40, 32'h40, 32'h41, 32'h41, 32'h42, 32'h42};

  initial begin
    reset = 0; cfg_base0 = 0; cfg_base1 = 0;
    idle_inputs();
    step(2);
    reset = 1;

    // Single requester pair, then a second pair at the bumped address.
    do_reset_load(32'h100, 32'h200);
    req0_valid = 1; req0_word = 32'h11111111; step();
    req0_word = 32'h22222222; step();
    req0_word = 32'h33333333; step();
    req0_word = 32'h44444444; step();
    req0_valid = 0; step(2);
    chk("t1_count", lq_addr.size(), 4);
    chk_log("t1_b0", 0, 0, 32'h100, 32'h11111111, 1);
    chk_log("t1_b1", 1, 0, 32'h100, 32'h22222222, 1);
    chk_log("t1_b2", 2, 0, 32'h101, 32'h33333333, 1);

    // Both requesters valid: pairs alternate.
    do_reset_load(32'h10, 32'h20);
    req0_valid = 1; req1_valid = 1; req0_word = 32'hA0A0A0A0; req1_word = 32'hB1B1B1B1;
    step(8);
    req0_valid = 0; req1_valid = 0; step(2);
    chk("t2_count", lq_addr.size(), 8);
    for (int i = 0; i < 8; i++) chk_log("t2", i, exp_own[i][0], exp_addr[i], 0, 0);

    // Odd-length stream gets padded; ready is low while the pad is emitted.
    do_reset_load(32'h0, 32'h40);
    req1_valid = 1; req1_word = 32'hA; step();
    req1_word = 32'hB; step();
    req1_word = 32'hC; req1_last = 1; step();
    req1_word = 32'hD;
    chk("t3_pad_ready", req1_ready, 0);
    step();
    step();
    req1_valid = 0; req1_last = 0; step(3);
    chk("t3_count", lq_addr.size(), 6);
    for (int i = 0; i < 6; i++) chk_log("t3", i, 1, t3_addr[i], t3_word[i], 1);

    // Backpressure mid-pair: the pair is never interleaved.
    do_reset_load(32'h80, 32'h90);
    req0_valid = 1; req0_word = 32'h01; req1_valid = 1; req1_word = 32'h02;
    step();
    out_ready = 0; step(3);
    chk("t4_stall_count", lq_addr.size(), 1);
    out_ready = 1; req0_word = 32'h03; step();
    req0_valid = 0; step(3);
    req1_valid = 0; step(2);
    chk_log("t4_b0", 0, 0, 32'h80, 32'h01, 1);
    chk_log("t4_b1", 1, 0, 32'h80, 32'h03, 1);
    chk_log("t4_b2", 2, 1, 32'h90, 32'h02, 1);

    // cfg_load ignored in SECOND, honoured (and blocking) in ARB.
    do_reset_load(32'h100, 32'h200);
    req0_valid = 1; req0_word = 32'h5; step();
    cfg_base0 = 32'h900; cfg_base1 = 32'h900; cfg_load = 1; req0_word = 32'h6; step();
    cfg_base0 = 32'h300; cfg_base1 = 32'h400;
    chk("t5_load_blocks", req0_ready, 0);
    step();
    cfg_load = 0; req0_word = 32'h7; step();
    req0_word = 32'h8; step();
    req0_valid = 0; step(2);
    chk("t5_count", lq_addr.size(), 4);
    chk_log("t5_b1", 1, 0, 32'h100, 32'h6, 1);
    chk_log("t5_b2", 2, 0, 32'h300, 32'h7, 1);
    chk_log("t5_b3", 3, 0, 32'h300, 32'h8, 1);

    // Reset in the middle of a pair.
    do_reset_load(32'h50, 32'h60);
    req0_valid = 1; req1_valid = 1; req0_word = 32'hCAFE; req1_word = 32'hBEEF;
    step();
    reset = 0; step();
    chk("t6_busy", busy, 0);
    chk("t6_en", pk_input_en, 0);
    chk("t6_word", pk_input_word, 0);
    chk("t6_addr", pk_input_addr, 0);
    chk("t6_owner", pk_owner, 0);
`ifdef STREAM_PACK_SCHED_STATS_EN
    chk("t6_stats", {stat_pairs0, stat_pairs1, stat_pads}, 0);
`endif
    lq_word.delete(); lq_addr.delete(); lq_own.delete();
    reset = 1; step(3);
    req0_valid = 0; req1_valid = 0; step(2);
    chk_log("t6_b0", 0, 0, 32'h0, 32'hCAFE, 1);

    // Address wrap.
    do_reset_load(32'hFFFFFFFF, 32'h0);
    req0_valid = 1; req0_word = 32'h77; step(4);
    req0_valid = 0; step(2);
    chk_log("t7_b1", 1, 0, 32'hFFFFFFFF, 32'h77, 1);
    chk_log("t7_b2", 2, 0, 32'h0, 32'h77, 1);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) != 0);
      cfg_load   = ($urandom_range(0, 29) == 0);
      cfg_base0  = $urandom;
      cfg_base1  = $urandom;
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_word  = $urandom;
      req1_word  = $urandom;
      req0_last  = ($urandom_range(0, 3) == 0);
      req1_last  = ($urandom_range(0, 3) == 0);
      out_ready  = ($urandom_range(0, 4) != 0);
      step();
    end
    reset = 1;
    idle_inputs();
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
